// File: rtl/synchronous_d_ff.sv
// Dual-output D register: Q1 uses the raw async reset, Q2 uses an async-assert /
// sync-release reset produced by an internal SYNC_STAGES-deep synchronizer.
module synchronous_d_ff #(
    parameter int unsigned       WIDTH       = 1,
    parameter logic [WIDTH-1:0]  RST_VAL     = '0,
    parameter int unsigned       SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q1,
    output logic [WIDTH-1:0] Q2
);

    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
            $error("synchronous_d_ff: SYNC_STAGES must be in 2..4");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rst_sync_n;

    // Reset synchronizer: clears at once, shifts ones in from stage 0 after release
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync_n = sync_q[SYNC_STAGES-1];

    // Q1: plain register on the raw reset
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            Q1 <= RST_VAL;
        end else begin
            Q1 <= D;
        end
    end

    // Q2: cleared immediately with RST_n, held until the synchronized release arrives
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            Q2 <= RST_VAL;
        end else if (!rst_sync_n) begin
            Q2 <= RST_VAL;
        end else begin
            Q2 <= D;
        end
    end

endmodule

// File: tb/tb_synchronous_d_ff.sv
// Scoreboard bench for synchronous_d_ff: two instances (1-bit/2 stages and 8-bit/A5/3 stages)
// checked against an edges-since-release reference model.
module tb_synchronous_d_ff;

    localparam int unsigned NA    = 2;
    localparam int unsigned NB    = 3;
    localparam logic [7:0]  RV_A  = 8'h00;
    localparam logic [7:0]  RV_B  = 8'hA5;

    typedef struct {
        logic [7:0] q1;
        logic [7:0] q2;
    } exp_t;

    logic       clk;
    logic       rst_a_n;
    logic       rst_b_n;
    logic       d_a;
    logic [7:0] d_b;
    logic       q1_a;
    logic       q2_a;
    logic [7:0] q1_b;
    logic [7:0] q2_b;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_a[$];
    exp_t sb_b[$];
    bit   armed_a = 1'b0;
    bit   armed_b = 1'b0;
    int   k_a = 0;
    int   k_b = 0;

    synchronous_d_ff #(.WIDTH(1), .RST_VAL(1'b0), .SYNC_STAGES(NA)) dut_a (
        .CLK  (clk),
        .RST_n(rst_a_n),
        .D    (d_a),
        .Q1   (q1_a),
        .Q2   (q2_a)
    );

    synchronous_d_ff #(.WIDTH(8), .RST_VAL(8'hA5), .SYNC_STAGES(NB)) dut_b (
        .CLK  (clk),
        .RST_n(rst_b_n),
        .D    (d_b),
        .Q1   (q1_b),
        .Q2   (q2_b)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: after the k-th edge since release Q1 = D, Q2 = D once k > stages
    always @(posedge clk) begin
        exp_t e;
        if (armed_a) begin
            if (!rst_a_n) begin
                k_a  = 0;
                e.q1 = RV_A;
                e.q2 = RV_A;
            end else begin
                k_a  = k_a + 1;
                e.q1 = 8'(d_a);
                e.q2 = (k_a >= int'(NA) + 1) ? 8'(d_a) : RV_A;
            end
            sb_a.push_back(e);
        end
        if (armed_b) begin
            if (!rst_b_n) begin
                k_b  = 0;
                e.q1 = RV_B;
                e.q2 = RV_B;
            end else begin
                k_b  = k_b + 1;
                e.q1 = d_b;
                e.q2 = (k_b >= int'(NB) + 1) ? d_b : RV_B;
            end
            sb_b.push_back(e);
        end
    end

    // Monitor A: samples 1 ns after every clock edge or reset assertion
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or negedge rst_a_n);
            #1;
            if (armed_a) begin
                if (sb_a.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL a_sb_empty at %0t: got no expectation, required one", $time);
                end else begin
                    e = sb_a.pop_front();
                    chk("a_q1", 8'(q1_a), e.q1);
                    chk("a_q2", 8'(q2_a), e.q2);
                end
            end
        end
    end

    // Monitor B
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or negedge rst_b_n);
            #1;
            if (armed_b) begin
                if (sb_b.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_sb_empty at %0t: got no expectation, required one", $time);
                end else begin
                    e = sb_b.pop_front();
                    chk("b_q1", q1_b, e.q1);
                    chk("b_q2", q2_b, e.q2);
                end
            end
        end
    end

    task automatic assert_rst_a();
        exp_t e;
        e.q1 = RV_A;
        e.q2 = RV_A;
        armed_a = 1'b1;
        k_a     = 0;
        sb_a.push_back(e);
        rst_a_n = 1'b0;
    endtask

    task automatic assert_rst_b();
        exp_t e;
        e.q1 = RV_B;
        e.q2 = RV_B;
        armed_b = 1'b1;
        k_b     = 0;
        sb_b.push_back(e);
        rst_b_n = 1'b0;
    endtask

    // Short mid-cycle reset pulse, kept well clear of the rising edge
    task automatic pulse_a(input int unsigned width_ns);
        @(negedge clk);
        #2;
        assert_rst_a();
        #(width_ns);
        rst_a_n = 1'b1;
    endtask

    task automatic pulse_b(input int unsigned width_ns);
        @(negedge clk);
        #2;
        assert_rst_b();
        #(width_ns);
        rst_b_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog at %0t: got timeout, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        d_a     = 1'b1;
        d_b     = 8'h00;

        // Mid-cycle reset at 20, release at 34, D pattern toggling at 60/80/120
        #20;
        assert_rst_a();
        #14 rst_a_n = 1'b1;
        #26 d_a = 1'b0;
        #20 d_a = 1'b1;
        #40 d_a = 1'b0;

        // Steady state random D
        @(negedge clk);
        repeat (100) begin
            d_a = 1'($urandom);
            @(negedge clk);
        end

        // Short reset pulses during random activity
        for (int p = 0; p < 4; p++) begin
            pulse_a(3 + $urandom_range(0, 2));
            repeat (6 + $urandom_range(0, 4)) begin
                @(negedge clk);
                d_a = 1'($urandom);
            end
        end

        // Wide instance: reset to A5, release with D = 3C
        @(negedge clk);
        assert_rst_b();
        repeat (2) @(negedge clk);
        rst_b_n = 1'b1;
        d_b     = 8'h3C;
        repeat (6) @(negedge clk);
        repeat (50) begin
            d_b = 8'($urandom);
            @(negedge clk);
        end
        for (int p = 0; p < 3; p++) begin
            pulse_b(1 + $urandom_range(0, 4));
            repeat (8 + $urandom_range(0, 3)) begin
                @(negedge clk);
                d_b = 8'($urandom);
            end
        end

        @(negedge clk);
        chk("a_sb_drained", 8'(sb_a.size()), 8'h00);
        chk("b_sb_drained", 8'(sb_b.size()), 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
